// File: rtl/mem_pkg.sv
// mem_pkg: funct3 load/store encodings, memory-stage FSM states and lane helpers.
package mem_pkg;
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    // op[1] selects word, op[0] selects halfword, otherwise byte
    function automatic logic aligned(input logic [2:0] op, input logic [1:0] a);
        return op[1] ? (a == 2'b00) : (op[0] ? ~a[0] : 1'b1);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
        return op[1] ? 4'b1111 : (op[0] ? (4'b0011 << {a[1], 1'b0}) : (4'b0001 << a));
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] sd);
        return op[1] ? sd : (op[0] ? {2{sd[15:0]}} : {4{sd[7:0]}});
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half of a read word and sign/zero extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_op,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    // op[2] marks the unsigned variants
    assign o_data = i_op[1] ? i_rdata :
                    i_op[0] ? {{16{w_half[15] & ~i_op[2]}}, w_half} :
                              {{24{w_byte[7] & ~i_op[2]}}, w_byte};
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage running loads/stores over a req/ack port with ack timeout,
// producing the write-back value and a PC stall while an access is in flight.
module mem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic        wb_valid,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_load;
    logic [31:0]       r_addr;
    logic [1:0]        r_lo;
    logic [2:0]        r_op;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [31:0]       r_lbuf;
    logic              r_mis;
    logic              r_berr;
    logic              w_mem_op;
    logic              w_aligned;
    logic [31:0]       w_ext;

    assign w_mem_op  = ex_valid & (mem_rd | mem_wr);
    assign w_aligned = aligned(mem_op, alu_result[1:0]);

    load_extend u_ext (
        .i_rdata (dmem_rdata),
        .i_addr  (r_lo),
        .i_op    (r_op),
        .o_data  (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_load  <= 1'b0;
            r_addr  <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_lbuf  <= '0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_mis  <= 1'b0;
            r_berr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && w_aligned) begin
                        r_state <= S_REQ;
                        r_addr  <= {alu_result[31:2], 2'b00};
                        r_lo    <= alu_result[1:0];
                        r_op    <= mem_op;
                        r_we    <= mem_wr;
                        r_load  <= ~mem_wr;
                        r_be    <= byte_en(mem_op, alu_result[1:0]);
                        r_wdata <= lane_data(mem_op, store_data);
                        r_cnt   <= '0;
                    end else if (w_mem_op) begin
                        r_state <= S_ERR;
                        r_mis   <= 1'b1;
                    end
                end
                S_REQ: begin
                    // an ack on the last allowed cycle still wins over the timeout
                    if (dmem_ack) begin
                        r_state <= S_DONE;
                        r_lbuf  <= w_ext;
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        r_state <= S_ERR;
                        r_berr  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign misalign   = r_mis;
    assign bus_err    = r_berr;
    assign stall      = (r_state == S_REQ) | ((r_state == S_IDLE) & w_mem_op);
    assign wb_valid   = (r_state == S_IDLE) ? (ex_valid & ~w_mem_op) : ((r_state == S_DONE) & r_load);
    assign wb_data    = (r_state == S_DONE) ? r_lbuf : alu_result;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed instruction streams checked cycle by cycle
// against a per-instruction timeline model of the memory stage.
module tb_mem_access;
    import mem_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, wb_data;
    logic [3:0]  dmem_be;
    logic        wb_valid, stall, misalign, bus_err;

    mem_access #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_op(mem_op), .alu_result(alu_result), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_data(wb_data), .wb_valid(wb_valid),
        .stall(stall), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, req, we, wbv, mis, berr;
        logic [31:0] addr, wdata, wbd;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0, n_err = 0;
    int          stall_cnt, req_cnt, wbv_cnt, mis_cnt, berr_cnt;
    logic [31:0] last_wb, last_wdata;
    logic [3:0]  last_be;
    logic [31:0] cur_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] rd, input logic [1:0] a, input logic [2:0] op);
        logic [31:0] v;
        case (op)
            MEM_B:  begin v = (rd >> (8 * a)) & 32'hFF; if (v[7]) v = v | 32'hFFFFFF00; end
            MEM_BU: v = (rd >> (8 * a)) & 32'hFF;
            MEM_H:  begin v = (rd >> (16 * a[1])) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
            MEM_HU: v = (rd >> (16 * a[1])) & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("dmem_req", 32'(dmem_req), 32'(e.req));
            chk("wb_valid", 32'(wb_valid), 32'(e.wbv));
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
            if (e.wbv) chk("wb_data", wb_data, e.wbd);
            if (e.req) begin
                chk("dmem_we", 32'(dmem_we), 32'(e.we));
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_be", 32'(dmem_be), 32'(e.be));
                chk("dmem_wdata", dmem_wdata, e.wdata);
            end
            if (stall) stall_cnt++;
            if (dmem_req) begin req_cnt++; last_be = dmem_be; last_wdata = dmem_wdata; end
            if (wb_valid) begin wbv_cnt++; last_wb = wb_data; end
            if (misalign) mis_cnt++;
            if (bus_err) berr_cnt++;
        end
    end

    task automatic clear_obs();
        stall_cnt = 0; req_cnt = 0; wbv_cnt = 0; mis_cnt = 0; berr_cnt = 0;
        last_wb = 'x; last_wdata = 'x; last_be = 'x;
    endtask

    task automatic cyc(input exp_t e, input logic ack);
        dmem_ack   = ack;
        dmem_rdata = ack ? cur_rdata : $urandom;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // wait_c >= TO means the memory never acks
    task automatic run_instr(input logic v, input logic rd, input logic wr, input logic [2:0] op,
                             input logic [31:0] alu, input logic [31:0] sd,
                             input logic [31:0] rdata, input int wait_c);
        exp_t        e;
        int          nb;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        nb = op[1] ? 4 : (op[0] ? 2 : 1);
        a  = alu[1:0];
        be = 4'(((1 << nb) - 1) << a);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nb) +: 8];
        ex_valid = v; mem_rd = rd; mem_wr = wr; mem_op = op;
        alu_result = alu; store_data = sd; cur_rdata = rdata;
        e = '{default: '0};
        if (!(v && (rd || wr))) begin
            e.wbv = v; e.wbd = alu;
            cyc(e, 1'($urandom_range(0, 1)));
            return;
        end
        e.stall = 1'b1;
        cyc(e, 1'($urandom_range(0, 1)));
        if ((int'(a) % nb) != 0) begin
            e = '{default: '0}; e.mis = 1'b1;
            cyc(e, 1'($urandom_range(0, 1)));
            return;
        end
        for (int k = 0; k < ((wait_c >= TO) ? TO : wait_c + 1); k++) begin
            e = '{default: '0};
            e.stall = 1'b1; e.req = 1'b1; e.we = wr;
            e.addr = {alu[31:2], 2'b00}; e.be = be; e.wdata = wd;
            cyc(e, wait_c < TO && k == wait_c);
        end
        e = '{default: '0};
        if (wait_c >= TO) e.berr = 1'b1;
        else begin e.wbv = !wr; e.wbd = m_ext(rdata, a, op); end
        cyc(e, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        ops = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
        clear_obs();
        #2;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_mis", 32'(misalign), 0);
        chk("rst_berr", 32'(bus_err), 0);
        chk("rst_stall", 32'(stall), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        clear_obs();
        run_instr(1, 1, 0, MEM_W, 32'h100, 0, 32'hDEADBEEF, 2);
        chk("t1_stall_cycles", stall_cnt, 4);
        chk("t1_req_cycles", req_cnt, 3);
        chk("t1_wb", last_wb, 32'hDEADBEEF);

        clear_obs();
        run_instr(1, 1, 0, MEM_B, 32'h103, 0, 32'h80123456, 0);
        chk("t2_lb_be", 32'(last_be), 32'h8);
        chk("t2_lb_wb", last_wb, 32'hFFFFFF80);
        clear_obs();
        run_instr(1, 1, 0, MEM_BU, 32'h103, 0, 32'h80123456, 1);
        chk("t2_lbu_wb", last_wb, 32'h00000080);

        clear_obs();
        run_instr(1, 0, 1, MEM_H, 32'h102, 32'h1234ABCD, 0, 1);
        chk("t3_sh_be", 32'(last_be), 32'hC);
        chk("t3_sh_wdata", last_wdata, 32'hABCDABCD);
        chk("t3_sh_wbv", wbv_cnt, 0);

        clear_obs();
        run_instr(1, 1, 0, MEM_W, 32'h101, 0, 0, 0);
        chk("t4_req", req_cnt, 0);
        chk("t4_mis", mis_cnt, 1);
        chk("t4_stall", stall_cnt, 1);

        clear_obs();
        run_instr(1, 1, 0, MEM_W, 32'h200, 0, 0, TO);
        chk("t5_req", req_cnt, TO);
        chk("t5_berr", berr_cnt, 1);
        run_instr(1, 0, 0, MEM_W, 32'h7, 0, 0, 0);

        ex_valid = 1; mem_rd = 1; mem_wr = 0; mem_op = MEM_W; alu_result = 32'h300; dmem_ack = 0;
        repeat (3) @(posedge clk);
        #1 chk("t6_req_before", 32'(dmem_req), 1);
        #2 rst = 1'b0;
        #1 chk("t6_req_reset", 32'(dmem_req), 0);
        chk("t6_berr_reset", 32'(bus_err), 0);
        ex_valid = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        clear_obs();
        run_instr(1, 0, 0, MEM_W, 32'h55AA0011, 0, 0, 0);
        chk("t6_add_wb", last_wb, 32'h55AA0011);
        chk("t6_add_stall", stall_cnt, 0);

        for (int n = 0; n < 300; n++) begin
            int          kind, w;
            logic [31:0] ad;
            kind = $urandom_range(0, 9);
            w = ($urandom_range(0, 19) == 0) ? TO : (($urandom_range(0, 19) == 0) ? TO - 1 : $urandom_range(0, 4));
            ad = $urandom;
            run_instr(kind != 0, kind < 4 || kind == 8, kind >= 4 && kind != 9,
                      ops[$urandom_range(0, 4)], ad, $urandom, $urandom, w);
        end

        ex_valid = 0; mem_rd = 0; mem_wr = 0; dmem_ack = 0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
